pulse_gate_scheduler: RTL



---
 rtl/pulse_gate_scheduler_pkg.sv | 52 +++++
 rtl/pulse_gate_scheduler_gate_timer.sv | 41 ++++
 rtl/pulse_gate_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pulse_gate_scheduler_pkg.sv
// rtl/pulse_gate_scheduler_pkg.sv - shared codes, gate lookup and FSM encodings for the gate scheduler
package pulse_gate_scheduler_pkg;

  localparam logic [7:0] TSEL_SYMBOL = 8'd5;
  localparam logic [7:0] TSEL_10MS   = 8'd6;
  localparam logic [7:0] TSEL_100MS  = 8'd7;
  localparam logic [7:0] TSEL_1S     = 8'd8;
  localparam logic [7:0] TSEL_10S    = 8'd9;

  localparam logic [7:0] DIV_1A = 8'd0;
  localparam logic [7:0] DIV_1B = 8'd1;
  localparam logic [7:0] DIV_2  = 8'd2;
  localparam logic [7:0] DIV_4  = 8'd3;
  localparam logic [7:0] DIV_8  = 8'd4;

  localparam logic [15:0] GATE_MS_10MS  = 16'd10;
  localparam logic [15:0] GATE_MS_100MS = 16'd100;
  localparam logic [15:0] GATE_MS_1S    = 16'd1000;
  localparam logic [15:0] GATE_MS_10S   = 16'd10000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_GATE  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_CALC  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  function automatic logic time_sel_valid(input logic [7:0] sel);
    return (sel > TSEL_SYMBOL) && (sel <= TSEL_10S);
  endfunction

  function automatic logic [15:0] gate_ms(input logic [7:0] sel);
    case (sel)
      TSEL_10MS:  return GATE_MS_10MS;
      TSEL_100MS: return GATE_MS_100MS;
      TSEL_1S:    return GATE_MS_1S;
      TSEL_10S:   return GATE_MS_10S;
      default:    return 16'd0;
    endcase
  endfunction

  function automatic logic [1:0] div_shift(input logic [7:0] code);
    case (code)
      DIV_1A, DIV_1B: return 2'd0;
      DIV_2:          return 2'd1;
      DIV_4:          return 2'd2;
      DIV_8:          return 2'd3;
      default:        return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pulse_gate_scheduler_gate_timer.sv
// rtl/pulse_gate_scheduler_gate_timer.sv - prescaler plus millisecond counter, flags the final gate cycle
module pulse_gate_scheduler_gate_timer #(
  parameter int TICKS_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic [15:0] ms_target_i,
  output logic        done_o
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);

  logic [PW-1:0] presc_q;
  logic [15:0]   ms_q;
  logic          presc_wrap;

  assign presc_wrap = (presc_q == PRESC_LAST);
  // done marks the last cycle of the window so the caller can leave GATE on the same edge
  assign done_o = run_i & presc_wrap & (ms_q == (ms_target_i - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (clear_i) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (run_i) begin
      if (presc_wrap) begin
        presc_q <= '0;
        ms_q    <= ms_q + 16'd1;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pulse_gate_scheduler.sv
// rtl/pulse_gate_scheduler.sv - clear/gate/latch sequencer delivering scaled samples to the plotter
module pulse_gate_scheduler
  import pulse_gate_scheduler_pkg::*;
#(
  parameter int TICKS_PER_MS       = 50000,
  parameter int SAMPLES_PER_PERIOD = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  iTime_Sel,
  input  logic [7:0]  iGain_Div,
  input  logic [7:0]  iPeriods_Num,
  input  logic [31:0] iCount,
  output logic        oCnt_Clear,
  output logic        oCnt_Gate,
  output logic        oCnt_Latch,
  output logic [15:0] oSample,
  output logic        oSample_Valid,
  input  logic        iSample_Ready,
  output logic [7:0]  oSample_Index,
  output logic        oFrame_Done,
  output logic        oBusy
);

  logic [2:0]  state_q, state_d;
  logic [7:0]  time_q, time_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  index_q, index_d;
  logic [15:0] sample_q, sample_d;
  logic        clear_q, gate_q, latch_q, valid_q, busy_q;
  logic        sel_valid, timer_done, accept, last_sample;
  logic [7:0]  periods_clamped;
  logic [31:0] shifted;

  assign sel_valid       = time_sel_valid(iTime_Sel);
  assign accept          = en & valid_q & iSample_Ready;
  assign last_sample     = (index_q == (len_q - 8'd1));
  assign periods_clamped = (iPeriods_Num > 8'd4) ? 8'd4 : iPeriods_Num;
  assign shifted         = iCount >> div_shift(div_q);

  pulse_gate_scheduler_gate_timer #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_gate_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (state_q == ST_CLEAR),
    .run_i      (state_q == ST_GATE),
    .ms_target_i(gate_ms(time_q)),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    div_d    = div_q;
    len_d    = len_q;
    index_d  = index_q;
    sample_d = sample_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        time_d = iTime_Sel;
        // frame length is only sampled at a frame boundary so a mid-frame menu edit waits
        if (index_q == 8'd0) len_d = 8'((32'(periods_clamped) + 32'd1) * SAMPLES_PER_PERIOD);
        state_d = sel_valid ? ST_GATE : ST_IDLE;
      end
      ST_GATE: begin
        if (iTime_Sel != time_q) state_d = sel_valid ? ST_CLEAR : ST_IDLE;
        else if (timer_done)     state_d = ST_LATCH;
      end
      ST_LATCH: begin
        div_d   = iGain_Div;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        sample_d = (|shifted[31:16]) ? 16'hFFFF : shifted[15:0];
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept) begin
          index_d = last_sample ? 8'd0 : (index_q + 8'd1);
          state_d = sel_valid ? ST_CLEAR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d  = ST_IDLE;
      index_d  = 8'd0;
      sample_d = 16'd0;
    end
  end

  // strobes decode the next state so every counter control comes straight off a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      time_q   <= 8'd0;
      div_q    <= 8'd0;
      len_q    <= 8'd0;
      index_q  <= 8'd0;
      sample_q <= 16'd0;
      clear_q  <= 1'b0;
      gate_q   <= 1'b0;
      latch_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      div_q    <= div_d;
      len_q    <= len_d;
      index_q  <= index_d;
      sample_q <= sample_d;
      clear_q  <= (state_d == ST_CLEAR);
      gate_q   <= (state_d == ST_GATE);
      latch_q  <= (state_d == ST_LATCH);
      valid_q  <= (state_d == ST_HOLD);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign oCnt_Clear    = clear_q;
  assign oCnt_Gate     = gate_q;
  assign oCnt_Latch    = latch_q;
  assign oSample       = sample_q;
  assign oSample_Valid = valid_q;
  assign oSample_Index = index_q;
  assign oFrame_Done   = accept & last_sample;
  assign oBusy         = busy_q;

endmodule
